nvdla_csb_initiator: RTL and testbench
======================================

Name: nvdla_csb_initiator

Overview:
- CSB master-side initiator; the requesting end of the csb2xx/xx2csb protocol served by unit-level CSB responders such as the config ROM.
- Converts a simple host register-access handshake into one 63-bit csb2xx request packet and collects the matching 34-bit xx2csb response.
- Provides timeout, misalignment and response-type checking.
- Used by bring-up/test logic and the CSB master path to access any unit's register file; one transaction outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for a response before a timeout completion; legal range 1..65535.
- REQ_LEVEL, 0: 2-bit value driven into packet field level.

Ports:
- nvdla_core_clk  input  1  core clock; all logic on rising edge.
- nvdla_core_rstn  input  1  asynchronous, active-low reset.
- host_req_valid  input  1  host request valid.
- host_req_ready  output  1  host request accepted when valid&ready.
- host_req_addr  input  24  byte address; [1:0] must be 0.
- host_req_wdat  input  32  write data.
- host_req_write  input  1  1=write, 0=read.
- host_req_nposted  input  1  write expects a response (ignored for reads).
- host_req_srcpriv  input  1  privileged source.
- host_req_wrbe  input  4  write byte enables.
- host_resp_valid  output  1  one-cycle completion pulse; no backpressure.
- host_resp_rdata  output  32  read data (0 for writes/errors).
- host_resp_error  output  1  completion error.
- host_resp_timeout  output  1  completion was a timeout.
- csb2xx_req_pvld  output  1  request valid.
- csb2xx_req_prdy  input  1  responder ready.
- csb2xx_req_pd  output  63  request packet.
- xx2csb_resp_valid  input  1  response valid.
- xx2csb_resp_pd  input  34  response packet.
- stray_resp  output  1  sticky flag: a response arrived when none was expected.

Behaviour:
- Request packet layout: [21:0] word address = host_req_addr[23:2]; [53:22] wdat; [54] write; [55] nposted (forced 0 for reads); [56] srcpriv; [60:57] wrbe; [62:61] REQ_LEVEL.
- Response packet layout: [31:0] data; [32] error; [33] type, 0=read, 1=write.
- Reset: all outputs 0; csb2xx_req_pd 0; stray_resp 0; FSM in IDLE; timer 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- host_req_ready = 1 only in IDLE.
- IDLE, host handshake with addr[1:0]!=0: no CSB request issued; go to RESP with error=1, rdata=0, timeout=0.
- IDLE, aligned handshake: register the packet; go to REQ. csb2xx_req_pvld rises the next cycle.
- REQ: pvld=1 and pd held stable until prdy=1. On the prdy cycle:
  - read or nposted write: go to WAIT, timer cleared;
  - posted write: go to RESP with error=0.
- WAIT, resp_valid sampled: go to RESP; rdata = pd[31:0] for reads, 0 for writes.
  - error = pd[32] | (pd[33] != expected type), where expected is 0 for read, 1 for write.
- WAIT, no response: timer increments each cycle. When the timer equals TIMEOUT_CYCLES-1 with no response, go to RESP with error=1, timeout=1, rdata=0.
  - A response arriving on that same cycle wins over the timeout.
- RESP: host_resp_valid=1 for exactly one cycle with registered rdata/error/timeout, then return to IDLE. Response outputs are 0 whenever valid=0.
- Stray responses: resp_valid in IDLE, REQ or RESP (including late responses after a timeout) is dropped and sets stray_resp. stray_resp clears only on reset.
- Latency against a zero-wait responder that answers 2 cycles after accepting: host handshake at cycle N; pvld at N+1; resp_valid at N+3; host_resp_valid at N+4.
- Back-to-back: the next host request can be accepted the cycle after host_resp_valid.
- Async reset mid-transaction: pvld drops immediately, FSM returns to IDLE, the transaction is lost and no completion is produced.

Test Plan:
- Read 0x000010 with responder returning pd={1'b0,1'b0,32'h0000_0A5A}: req_pd[21:0]=0x4, [54]=0; host_resp_rdata=0x0A5A, error=0, valid 4 cycles after the handshake.
- Non-posted write addr 0x000100, wdat 0xDEADBEEF, wrbe 0xF; response type=1 -> pd[21:0]=0x40, [53:22]=0xDEADBEEF, [55]=1; completion error=0, rdata=0. Repeat with posted write -> completion the cycle after prdy, no WAIT.
- Read with prdy held low 5 cycles -> pvld and pd stable for 6 cycles; completion follows the response correctly.
- TIMEOUT_CYCLES=8, responder silent -> completion error=1, timeout=1, 8 cycles after prdy; a late response 3 cycles later sets stray_resp=1 and produces no completion.
- Read returning type=1 -> error=1; addr 0x000013 -> immediate completion error=1, pvld never asserted.
- Assert rstn low during WAIT -> all outputs 0 asynchronously; after release a new read completes normally.

Source files
------------

// File: rtl/nvdla_csb_initiator_if.sv
// ============================================================================
// nvdla_csb_initiator_if : host request/response and csb2xx/xx2csb bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface nvdla_csb_initiator_if;
   logic        host_req_valid;
   logic        host_req_ready;
   logic [23:0] host_req_addr;
   logic [31:0] host_req_wdat;
   logic        host_req_write;
   logic        host_req_nposted;
   logic        host_req_srcpriv;
   logic [3:0]  host_req_wrbe;
   logic        host_resp_valid;
   logic [31:0] host_resp_rdata;
   logic        host_resp_error;
   logic        host_resp_timeout;
   logic        csb2xx_req_pvld;
   logic        csb2xx_req_prdy;
   logic [62:0] csb2xx_req_pd;
   logic        xx2csb_resp_valid;
   logic [33:0] xx2csb_resp_pd;
   logic        stray_resp;

   modport master (
      input  host_req_valid, host_req_addr, host_req_wdat, host_req_write,
             host_req_nposted, host_req_srcpriv, host_req_wrbe,
             csb2xx_req_prdy, xx2csb_resp_valid, xx2csb_resp_pd,
      output host_req_ready, host_resp_valid, host_resp_rdata, host_resp_error,
             host_resp_timeout, csb2xx_req_pvld, csb2xx_req_pd, stray_resp
   );

   modport slave (
      output host_req_valid, host_req_addr, host_req_wdat, host_req_write,
             host_req_nposted, host_req_srcpriv, host_req_wrbe,
             csb2xx_req_prdy, xx2csb_resp_valid, xx2csb_resp_pd,
      input  host_req_ready, host_resp_valid, host_resp_rdata, host_resp_error,
             host_resp_timeout, csb2xx_req_pvld, csb2xx_req_pd, stray_resp
   );
endinterface

`default_nettype wire

// File: rtl/nvdla_csb_initiator.sv
// ============================================================================
// nvdla_csb_initiator : single-outstanding CSB master with timeout/error checks
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module nvdla_csb_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [1:0]  REQ_LEVEL      = 2'd0
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rstn,
   nvdla_csb_initiator_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic        ready_q;
   logic        pvld_q;
   logic [62:0] pd_q;
   logic        write_q;
   logic        nposted_q;
   logic [15:0] timer_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic        rerr_q;
   logic        rto_q;
   logic        stray_q;
   logic [62:0] pkt_d;

   // Reads never carry nposted: a read always gets a response.
   assign pkt_d = {REQ_LEVEL, bus.host_req_wrbe, bus.host_req_srcpriv,
                   bus.host_req_write & bus.host_req_nposted, bus.host_req_write,
                   bus.host_req_wdat, bus.host_req_addr[23:2]};

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         pvld_q    <= 1'b0;
         pd_q      <= '0;
         write_q   <= 1'b0;
         nposted_q <= 1'b0;
         timer_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rerr_q    <= 1'b0;
         rto_q     <= 1'b0;
         stray_q   <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
         rto_q    <= 1'b0;
         if (bus.xx2csb_resp_valid && state_q != WAIT) begin
            stray_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (bus.host_req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  if (bus.host_req_addr[1:0] != 2'b00) begin
                     state_q  <= RESP;
                     rvalid_q <= 1'b1;
                     rerr_q   <= 1'b1;
                  end else begin
                     state_q   <= REQ;
                     pvld_q    <= 1'b1;
                     pd_q      <= pkt_d;
                     write_q   <= bus.host_req_write;
                     nposted_q <= bus.host_req_write & bus.host_req_nposted;
                  end
               end
            end
            REQ: begin
               if (bus.csb2xx_req_prdy) begin
                  pvld_q  <= 1'b0;
                  timer_q <= '0;
                  if (write_q && !nposted_q) begin
                     state_q  <= RESP;
                     rvalid_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               // A response on the final timer cycle takes priority over the timeout.
               if (bus.xx2csb_resp_valid) begin
                  state_q  <= RESP;
                  rvalid_q <= 1'b1;
                  rdata_q  <= write_q ? 32'd0 : bus.xx2csb_resp_pd[31:0];
                  rerr_q   <= bus.xx2csb_resp_pd[32] | (bus.xx2csb_resp_pd[33] != write_q);
               end else if (timer_q == C_TMO_LAST) begin
                  state_q  <= RESP;
                  rvalid_q <= 1'b1;
                  rerr_q   <= 1'b1;
                  rto_q    <= 1'b1;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.host_req_ready    = ready_q;
   assign bus.host_resp_valid   = rvalid_q;
   assign bus.host_resp_rdata   = rdata_q;
   assign bus.host_resp_error   = rerr_q;
   assign bus.host_resp_timeout = rto_q;
   assign bus.csb2xx_req_pvld   = pvld_q;
   assign bus.csb2xx_req_pd     = pd_q;
   assign bus.stray_resp        = stray_q;

endmodule

`default_nettype wire

// File: tb/tb_nvdla_csb_initiator.sv
// ============================================================================
// tb_nvdla_csb_initiator : directed + randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nvdla_csb_initiator;
   localparam int         TMO = 8;
   localparam logic [1:0] LVL = 2'd2;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   nvdla_csb_initiator_if bus ();

   nvdla_csb_initiator #(
      .TIMEOUT_CYCLES (TMO),
      .REQ_LEVEL      (LVL)
   ) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .bus             (bus)
   );

   int   n_pass    = 0;
   int   n_total   = 0;
   logic exp_stray = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [62:0] model_pkt(input logic [23:0] addr, input logic [31:0] wdat,
                                              input bit write, input bit np, input bit priv,
                                              input logic [3:0] wrbe);
      logic [62:0] p;
      p = 63'(addr >> 2);
      p = p | (63'(wdat) << 22);
      p = p | (63'(write) << 54);
      p = p | (63'(write & np) << 55);
      p = p | (63'(priv) << 56);
      p = p | (63'(wrbe) << 57);
      p = p | (63'(LVL) << 61);
      return p;
   endfunction

   // d: cycles prdy is held low; k: cycles after accept the responder answers (0 = silent)
   task automatic run_txn(input logic [23:0] addr, input logic [31:0] wdat, input bit write,
                          input bit np, input bit priv, input logic [3:0] wrbe,
                          input int d, input int k, input logic [33:0] rpd);
      int          tc;
      bit          mis, posted;
      logic [62:0] e_pd;
      logic [31:0] e_rd;
      logic        e_err, e_to;
      mis    = (addr % 4) != 0;
      posted = write && !np;
      e_pd   = model_pkt(addr, wdat, write, np, priv, wrbe);
      e_rd   = 32'd0;
      e_err  = 1'b0;
      e_to   = 1'b0;
      if (mis) begin
         tc = 1; e_err = 1'b1;
      end else if (posted) begin
         tc = 2 + d;
      end else if (k == 0) begin
         tc = 2 + d + TMO; e_err = 1'b1; e_to = 1'b1;
      end else begin
         tc    = 2 + d + k;
         e_rd  = write ? 32'd0 : rpd[31:0];
         e_err = rpd[32] | (rpd[33] != write);
      end
      chk("ready_idle", 64'(bus.host_req_ready), 64'd1);
      bus.host_req_valid   = 1'b1;
      bus.host_req_addr    = addr;
      bus.host_req_wdat    = wdat;
      bus.host_req_write   = write;
      bus.host_req_nposted = np;
      bus.host_req_srcpriv = priv;
      bus.host_req_wrbe    = wrbe;
      bus.xx2csb_resp_pd   = rpd;
      for (int t = 1; t <= tc; t++) begin
         step();
         bus.host_req_valid    = 1'b0;
         bus.csb2xx_req_prdy   = !mis && (t == 1 + d);
         bus.xx2csb_resp_valid = !mis && !posted && (k != 0) && (t == 1 + d + k);
         chk("pvld", 64'(bus.csb2xx_req_pvld), 64'(!mis && t <= 1 + d));
         if (!mis && t <= 1 + d) chk("req_pd", 64'(bus.csb2xx_req_pd), 64'(e_pd));
         chk("resp_valid", 64'(bus.host_resp_valid), 64'(t == tc));
         if (t == tc) begin
            chk("resp_rdata",   64'(bus.host_resp_rdata),   64'(e_rd));
            chk("resp_error",   64'(bus.host_resp_error),   64'(e_err));
            chk("resp_timeout", 64'(bus.host_resp_timeout), 64'(e_to));
         end else begin
            chk("busy_ready", 64'(bus.host_req_ready), 64'd0);
            chk("idle_resp_zero", 64'({bus.host_resp_rdata, bus.host_resp_error,
                                        bus.host_resp_timeout}), 64'd0);
         end
      end
      chk("stray", 64'(bus.stray_resp), 64'(exp_stray));
      step();
   endtask

   initial begin
      logic [23:0] a;
      bit          w;
      int          k;
      logic [33:0] rpd;

      bus.host_req_valid    = 1'b0;
      bus.host_req_addr     = '0;
      bus.host_req_wdat     = '0;
      bus.host_req_write    = 1'b0;
      bus.host_req_nposted  = 1'b0;
      bus.host_req_srcpriv  = 1'b0;
      bus.host_req_wrbe     = '0;
      bus.csb2xx_req_prdy   = 1'b0;
      bus.xx2csb_resp_valid = 1'b0;
      bus.xx2csb_resp_pd    = '0;

      #1;
      chk("rst_pvld",  64'(bus.csb2xx_req_pvld), 64'd0);
      chk("rst_pd",    64'(bus.csb2xx_req_pd),   64'd0);
      chk("rst_ready", 64'(bus.host_req_ready),  64'd0);
      chk("rst_rvld",  64'(bus.host_resp_valid), 64'd0);
      chk("rst_stray", 64'(bus.stray_resp),      64'd0);
      @(negedge clk);
      rstn = 1'b1;
      step();

      // Read returning 0xA5A with the 2-cycle responder
      run_txn(24'h000010, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 2, {1'b0, 1'b0, 32'h0000_0A5A});
      // Non-posted then posted write
      run_txn(24'h000100, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 4'hF, 0, 2, {1'b1, 1'b0, 32'h1234_5678});
      run_txn(24'h000100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 4'hF, 0, 0, 34'h0);
      // prdy held low 5 cycles
      run_txn(24'h00ABC0, 32'h0, 1'b0, 1'b1, 1'b0, 4'h3, 5, 2, {1'b0, 1'b0, 32'hCAFE_F00D});
      // Read returning type=1 -> error
      run_txn(24'h000020, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 2, {1'b1, 1'b0, 32'h0000_1111});
      // Misaligned address
      run_txn(24'h000013, 32'h5555, 1'b1, 1'b1, 1'b0, 4'hF, 0, 2, 34'h0);
      // Response on the last timer cycle wins over the timeout
      run_txn(24'h000040, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, TMO, {1'b0, 1'b1, 32'h0000_7777});

      // Silent responder -> timeout, then a late response is a stray
      run_txn(24'h000080, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 34'h0);
      step();
      step();
      bus.xx2csb_resp_valid = 1'b1;
      bus.xx2csb_resp_pd    = {1'b0, 1'b0, 32'hBAD0_BAD0};
      step();
      bus.xx2csb_resp_valid = 1'b0;
      exp_stray = 1'b1;
      chk("late_no_cpl", 64'(bus.host_resp_valid), 64'd0);
      chk("late_stray",  64'(bus.stray_resp),      64'd1);
      step();
      chk("late_no_cpl2", 64'(bus.host_resp_valid), 64'd0);

      // Asynchronous reset while waiting for a response
      bus.host_req_valid = 1'b1;
      bus.host_req_addr  = 24'h000200;
      bus.host_req_write = 1'b0;
      step();
      bus.host_req_valid  = 1'b0;
      bus.csb2xx_req_prdy = 1'b1;
      step();
      bus.csb2xx_req_prdy = 1'b0;
      step();
      #2 rstn = 1'b0;
      exp_stray = 1'b0;
      #1;
      chk("arst_pvld",  64'(bus.csb2xx_req_pvld), 64'd0);
      chk("arst_ready", 64'(bus.host_req_ready),  64'd0);
      chk("arst_rvld",  64'(bus.host_resp_valid), 64'd0);
      chk("arst_pd",    64'(bus.csb2xx_req_pd),   64'd0);
      chk("arst_stray", 64'(bus.stray_resp),      64'd0);
      @(negedge clk);
      rstn = 1'b1;
      step();
      run_txn(24'h000204, 32'h0, 1'b0, 1'b0, 1'b1, 4'h0, 0, 2, {1'b0, 1'b0, 32'h0BAD_CAFE});

      // Randomized traffic
      for (int i = 0; i < 30; i++) begin
         a = 24'($urandom) & 24'hFFFFFC;
         if ($urandom_range(0, 7) == 0) a = a | 24'($urandom_range(1, 3));
         w = 1'($urandom_range(0, 1));
         k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
         rpd = {w ^ ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 32'($urandom)};
         run_txn(a, 32'($urandom), w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom), int'($urandom_range(0, 4)), k, rpd);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
